ec_scalar_mult_ctrl: RTL and testbench
======================================

// Module: ec_scalar_mult_ctrl
// PURPOSE
//  Initiator for the EC point engine (EC_TOP) request/response interface.
//  - Computes R = k*P over GF(p) by left-to-right double-and-add.
//  - Issues one engine request per DOUBLE or ADD step.
//  - Handles the point at infinity, which the engine cannot represent.
//  - Sits between the host command port and one EC_TOP instance.
// PARAMETERS
//  W        6   field/coordinate width; matches engine port width
//  K_W      6   scalar width
//  TIMEOUT  64  max cycles waiting for ec_out_valid (used only with EC_SM_TIMEOUT_EN)
// PORTS
//  clk          in   1    clock; all logic on posedge
//  rst          in   1    synchronous, active-high reset
//  in_valid     in   1    1-cycle command strobe; ignored unless busy==0
//  in_k         in   K_W  scalar k
//  in_Px/in_Py  in   W    base point P; caller guarantees P is on the curve
//  in_prime     in   W    field prime p
//  in_a         in   W    curve coefficient a
//  busy         out  1    high from the cycle after command capture until the out_valid cycle
//  out_valid    out  1    1-cycle result strobe
//  out_Rx/out_Ry out W    result coordinates; 0 when out_inf=1 or out_valid=0
//  out_inf      out  1    result is the point at infinity
//  out_err      out  1    engine timeout (EC_SM_TIMEOUT_EN only; otherwise tied 0)
//  ec_in_valid  out  1    engine request strobe, 1 cycle
//  ec_Px/Py/Qx/Qy/prime/a out W  engine operands; 0 when ec_in_valid=0
//  ec_out_valid in   1    engine response strobe
//  ec_Rx/ec_Ry  in   W    engine result
// BEHAVIOUR
//  Reset: state=IDLE; every output and the internal acc/P/k regs clear to 0.
//  FSM: IDLE -> LOAD -> STEP -> {REQ -> WAIT -> STEP} ... -> DONE -> IDLE.
//  - IDLE: when in_valid=1, latch k, P, p and a; go to LOAD.
//  - LOAD: if k==0, go to DONE with the result infinite.
//    Else set acc=P and bit index i = msb(k)-1 (priority encoder, 1 cycle), then go to STEP.
//    If msb(k)==0, go straight to DONE.
//  - STEP, per bit i (MSB-1 down to 0), phase DBL then, if k[i]==1, phase ADD:
//    - DBL: if acc is infinity or acc.y==0, acc becomes infinity with no request.
//      Otherwise REQ with Q=acc, P=acc.
//    - ADD: if acc is infinity, acc=P with no request.
//      Else if acc.x==P.x and acc.y!=P.y, acc becomes infinity with no request.
//      Otherwise REQ with P, Q=acc. The engine itself handles acc==P as a doubling.
//    - Advance to the next phase or bit. After bit 0 completes, go to DONE.
//  - REQ: drive ec_in_valid=1 for exactly one cycle, then go to WAIT.
//  - WAIT: hold ec_in_valid=0. On ec_out_valid, load acc from ec_Rx/ec_Ry and return to STEP.
//    Only one request is outstanding at any time.
//  - DONE: drive out_valid=1 for one cycle with acc/out_inf; busy drops in this same cycle; go to IDLE.
//  Boundary rules:
//  - A no-request step (infinity shortcut) costs 1 cycle in STEP.
//  - ec_out_valid outside WAIT is ignored.
//  - in_valid while busy is dropped. A new command is accepted in the cycle after out_valid.
//  - rst mid-operation aborts immediately with no out_valid. An in-flight engine response after reset is ignored.
//  - Coordinates are W-bit unsigned, always < p. No arithmetic is done here; compares are equality only.
// CONFIGURATION
//  EC_SM_TIMEOUT_EN:
//  - Defined: a counter runs in WAIT.
//    If it reaches TIMEOUT with no ec_out_valid, go to DONE with out_valid=1, out_err=1, out_inf=0 and Rx/Ry=0.
//    The counter clears on every REQ.
//  - Undefined: no counter; WAIT holds indefinitely; out_err is tied 0.
// TESTING  (curve y^2=x^3+x+6 mod 11, a=1, P=(2,7); order 13)
//  1. k=0 -> out_valid after LOAD, out_inf=1, Rx=Ry=0; zero ec_in_valid pulses.
//  2. k=1 -> out (2,7), out_inf=0; zero engine requests.
//  3. k=2 -> one request (P=Q=(2,7)); engine stub returns (5,2) -> out (5,2).
//  4. k=3 -> requests DBL then ADD -> out (8,3); exactly 2 ec_in_valid pulses.
//  5. k=13 -> after 12P=(2,4), the final ADD hits the x-equal/y-differ case.
//     -> out_inf=1; 4 engine requests total, none for that final add.
//  6. Engine stub never responds; with EC_SM_TIMEOUT_EN -> out_err=1 at TIMEOUT cycles in WAIT.
//     Also assert rst mid-WAIT -> outputs 0, IDLE, no out_valid.

Source files
------------

// File: rtl/ec_scalar_mult_ctrl_if.sv
// Port bundles for ec_scalar_mult_ctrl.
//  ec_cmd_if : host command port (master = host, slave = controller)
//  ec_eng_if : EC engine request/response port (master = controller, slave = engine)
interface ec_cmd_if #(
  parameter int W   = 6,
  parameter int K_W = 6
);
  logic           in_valid;
  logic [K_W-1:0] in_k;
  logic [W-1:0]   in_Px;
  logic [W-1:0]   in_Py;
  logic [W-1:0]   in_prime;
  logic [W-1:0]   in_a;
  logic           busy;
  logic           out_valid;
  logic [W-1:0]   out_Rx;
  logic [W-1:0]   out_Ry;
  logic           out_inf;
  logic           out_err;

  modport master (
    output in_valid, in_k, in_Px, in_Py, in_prime, in_a,
    input  busy, out_valid, out_Rx, out_Ry, out_inf, out_err
  );

  modport slave (
    input  in_valid, in_k, in_Px, in_Py, in_prime, in_a,
    output busy, out_valid, out_Rx, out_Ry, out_inf, out_err
  );
endinterface

interface ec_eng_if #(
  parameter int W = 6
);
  logic         ec_in_valid;
  logic [W-1:0] ec_Px;
  logic [W-1:0] ec_Py;
  logic [W-1:0] ec_Qx;
  logic [W-1:0] ec_Qy;
  logic [W-1:0] ec_prime;
  logic [W-1:0] ec_a;
  logic         ec_out_valid;
  logic [W-1:0] ec_Rx;
  logic [W-1:0] ec_Ry;

  modport master (
    output ec_in_valid, ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a,
    input  ec_out_valid, ec_Rx, ec_Ry
  );

  modport slave (
    input  ec_in_valid, ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a,
    output ec_out_valid, ec_Rx, ec_Ry
  );
endinterface

// File: rtl/ec_scalar_mult_ctrl.sv
// ec_scalar_mult_ctrl: computes R = k*P by left-to-right double-and-add,
// issuing one EC engine request per DOUBLE/ADD step. The point at infinity
// is tracked locally because the engine cannot represent it.
// Optional feature macro: EC_SM_TIMEOUT_EN (abort a WAIT after TIMEOUT cycles
// with out_err=1; when undefined WAIT holds forever and out_err is tied 0).
module ec_scalar_mult_ctrl #(
  parameter int W       = 6,
  parameter int K_W     = 6,
  parameter int TIMEOUT = 64
) (
  input logic      clk,
  input logic      rst,
  ec_cmd_if.slave  cmd,
  ec_eng_if.master eng
);

  localparam int IdxW = (K_W > 1) ? $clog2(K_W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STEP,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t          state_q;
  logic [K_W-1:0]  k_q;
  logic [W-1:0]    px_q, py_q, prime_q, a_q;
  logic [W-1:0]    accX_q, accY_q;
  logic            accInf_q;
  logic [IdxW-1:0] bitIdx_q;
  logic            phaseAdd_q;
  logic            finished_q;
  logic            busy_q, outValid_q, outInf_q;
  logic [W-1:0]    outRx_q, outRy_q;
  logic            ecValid_q;
  logic [W-1:0]    ecPx_q, ecPy_q, ecQx_q, ecQy_q, ecPrime_q, ecA_q;

  logic            kBit;
  logic            accYZero;
  logic            addCancels;
  logic [IdxW-1:0] loadIdx;
  logic            nextPhaseAdd_d;
  logic [IdxW-1:0] nextIdx_d;
  logic            stepLast_d;

  // Priority encoder: index of the most significant set bit of k.
  function automatic logic [IdxW-1:0] msbIndex(input logic [K_W-1:0] k);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int i = 0; i < K_W; i++) begin
      if (k[i]) idx = IdxW'(i);
    end
    return idx;
  endfunction

  // Work out where the walk goes once the current phase completes.
  always_comb begin
    kBit           = k_q[bitIdx_q];
    accYZero       = (accY_q == '0);
    addCancels     = (accX_q == px_q) && (accY_q != py_q);
    loadIdx        = msbIndex(k_q);
    nextPhaseAdd_d = 1'b0;
    nextIdx_d      = bitIdx_q;
    stepLast_d     = 1'b0;
    if (!phaseAdd_q && kBit) begin
      nextPhaseAdd_d = 1'b1;
    end else if (bitIdx_q == '0) begin
      stepLast_d = 1'b1;
    end else begin
      nextIdx_d = bitIdx_q - 1'b1;
    end
  end

`ifdef EC_SM_TIMEOUT_EN
  localparam int TmrW = $clog2(TIMEOUT + 1);
  logic [TmrW-1:0] timer_q;
  logic            outErr_q;
  assign cmd.out_err = outErr_q;
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT == 0);
  assign cmd.out_err   = 1'b0;
`endif

  // Main controller FSM with registered host and engine outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      px_q       <= '0;
      py_q       <= '0;
      prime_q    <= '0;
      a_q        <= '0;
      accX_q     <= '0;
      accY_q     <= '0;
      accInf_q   <= 1'b0;
      bitIdx_q   <= '0;
      phaseAdd_q <= 1'b0;
      finished_q <= 1'b0;
      busy_q     <= 1'b0;
      outValid_q <= 1'b0;
      outRx_q    <= '0;
      outRy_q    <= '0;
      outInf_q   <= 1'b0;
      ecValid_q  <= 1'b0;
      ecPx_q     <= '0;
      ecPy_q     <= '0;
      ecQx_q     <= '0;
      ecQy_q     <= '0;
      ecPrime_q  <= '0;
      ecA_q      <= '0;
`ifdef EC_SM_TIMEOUT_EN
      timer_q    <= '0;
      outErr_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd.in_valid) begin
            k_q     <= cmd.in_k;
            px_q    <= cmd.in_Px;
            py_q    <= cmd.in_Py;
            prime_q <= cmd.in_prime;
            a_q     <= cmd.in_a;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          accX_q     <= px_q;
          accY_q     <= py_q;
          accInf_q   <= 1'b0;
          phaseAdd_q <= 1'b0;
          finished_q <= 1'b0;
          if (k_q == '0) begin
            accInf_q   <= 1'b1;
            busy_q     <= 1'b0;
            outValid_q <= 1'b1;
            outInf_q   <= 1'b1;
            state_q    <= ST_DONE;
          end else if (loadIdx == '0) begin
            busy_q     <= 1'b0;
            outValid_q <= 1'b1;
            outRx_q    <= px_q;
            outRy_q    <= py_q;
            state_q    <= ST_DONE;
          end else begin
            bitIdx_q <= loadIdx - 1'b1;
            state_q  <= ST_STEP;
          end
        end

        ST_STEP: begin
          if (finished_q) begin
            busy_q     <= 1'b0;
            outValid_q <= 1'b1;
            outInf_q   <= accInf_q;
            outRx_q    <= accInf_q ? '0 : accX_q;
            outRy_q    <= accInf_q ? '0 : accY_q;
            state_q    <= ST_DONE;
          end else if (!phaseAdd_q && (accInf_q || accYZero)) begin
            accInf_q <= 1'b1;
            if (stepLast_d) begin
              busy_q     <= 1'b0;
              outValid_q <= 1'b1;
              outInf_q   <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              phaseAdd_q <= nextPhaseAdd_d;
              bitIdx_q   <= nextIdx_d;
            end
          end else if (phaseAdd_q && accInf_q) begin
            accX_q   <= px_q;
            accY_q   <= py_q;
            accInf_q <= 1'b0;
            if (stepLast_d) begin
              busy_q     <= 1'b0;
              outValid_q <= 1'b1;
              outRx_q    <= px_q;
              outRy_q    <= py_q;
              state_q    <= ST_DONE;
            end else begin
              phaseAdd_q <= nextPhaseAdd_d;
              bitIdx_q   <= nextIdx_d;
            end
          end else if (phaseAdd_q && addCancels) begin
            accInf_q <= 1'b1;
            if (stepLast_d) begin
              busy_q     <= 1'b0;
              outValid_q <= 1'b1;
              outInf_q   <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              phaseAdd_q <= nextPhaseAdd_d;
              bitIdx_q   <= nextIdx_d;
            end
          end else begin
            ecValid_q  <= 1'b1;
            ecPx_q     <= phaseAdd_q ? px_q : accX_q;
            ecPy_q     <= phaseAdd_q ? py_q : accY_q;
            ecQx_q     <= accX_q;
            ecQy_q     <= accY_q;
            ecPrime_q  <= prime_q;
            ecA_q      <= a_q;
            phaseAdd_q <= nextPhaseAdd_d;
            bitIdx_q   <= nextIdx_d;
            finished_q <= stepLast_d;
            state_q    <= ST_REQ;
          end
        end

        ST_REQ: begin
          ecValid_q <= 1'b0;
          ecPx_q    <= '0;
          ecPy_q    <= '0;
          ecQx_q    <= '0;
          ecQy_q    <= '0;
          ecPrime_q <= '0;
          ecA_q     <= '0;
`ifdef EC_SM_TIMEOUT_EN
          timer_q   <= '0;
`endif
          state_q   <= ST_WAIT;
        end

        ST_WAIT: begin
          if (eng.ec_out_valid) begin
            accX_q   <= eng.ec_Rx;
            accY_q   <= eng.ec_Ry;
            accInf_q <= 1'b0;
            state_q  <= ST_STEP;
          end
`ifdef EC_SM_TIMEOUT_EN
          else if (timer_q == TmrW'(TIMEOUT - 1)) begin
            busy_q     <= 1'b0;
            outValid_q <= 1'b1;
            outErr_q   <= 1'b1;
            outInf_q   <= 1'b0;
            outRx_q    <= '0;
            outRy_q    <= '0;
            state_q    <= ST_DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`endif
        end

        ST_DONE: begin
          outValid_q <= 1'b0;
          outRx_q    <= '0;
          outRy_q    <= '0;
          outInf_q   <= 1'b0;
`ifdef EC_SM_TIMEOUT_EN
          outErr_q   <= 1'b0;
`endif
          state_q    <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd.busy      = busy_q;
  assign cmd.out_valid = outValid_q;
  assign cmd.out_Rx    = outRx_q;
  assign cmd.out_Ry    = outRy_q;
  assign cmd.out_inf   = outInf_q;

  assign eng.ec_in_valid = ecValid_q;
  assign eng.ec_Px       = ecPx_q;
  assign eng.ec_Py       = ecPy_q;
  assign eng.ec_Qx       = ecQx_q;
  assign eng.ec_Qy       = ecQy_q;
  assign eng.ec_prime    = ecPrime_q;
  assign eng.ec_a        = ecA_q;

endmodule

// File: tb/tb_ec_scalar_mult_ctrl.sv
// Testbench for ec_scalar_mult_ctrl: random curves/scalars checked against a
// group-law reference model, plus the directed cases on y^2=x^3+x+6 mod 11.
module tb_ec_scalar_mult_ctrl;

  localparam int W       = 6;
  localparam int K_W     = 6;
  localparam int TIMEOUT = 64;
  localparam int MAXC    = 3000;

  typedef struct {
    bit inf;
    int x;
    int y;
  } pt_t;

  logic clk;
  logic rst;
  int   checkCount = 0;
  int   errorCount = 0;
  int   cyc = 0;
  int   reqCount = 0;
  int   reqCyc = 0;
  int   doneCyc = 0;
  bit   stubSilent = 0;
  bit   strayReq = 0;
  bit   stubPending = 0;
  int   stubDelay = 0;
  int   stubRx = 0;
  int   stubRy = 0;

  ec_cmd_if #(.W(W), .K_W(K_W)) cmdIf ();
  ec_eng_if #(.W(W)) engIf ();

  ec_scalar_mult_ctrl #(.W(W), .K_W(K_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .cmd (cmdIf),
    .eng (engIf)
  );

  // Free-running clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Counts a comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int modP(input int v, input int p);
    return ((v % p) + p) % p;
  endfunction

  function automatic int invMod(input int v, input int p);
    int r = 1;
    int b = modP(v, p);
    for (int i = 0; i < p - 2; i++) r = (r * b) % p;
    return r;
  endfunction

  function automatic pt_t mkPt(input bit inf, input int x, input int y);
    pt_t r;
    r.inf = inf;
    r.x = x;
    r.y = y;
    return r;
  endfunction

  // Elliptic curve group law over GF(p), infinity included.
  function automatic pt_t ptAdd(input pt_t u, input pt_t v, input int p, input int ac);
    pt_t r;
    int l;
    r = mkPt(0, 0, 0);
    if (u.inf) return v;
    if (v.inf) return u;
    if (u.x == v.x) begin
      if (u.y != v.y || u.y == 0) begin
        r.inf = 1;
        return r;
      end
      l = modP((3 * u.x * u.x + ac) * invMod(2 * u.y, p), p);
    end else begin
      l = modP(modP(v.y - u.y, p) * invMod(v.x - u.x, p), p);
    end
    r.x = modP(l * l - u.x - v.x, p);
    r.y = modP(l * (u.x - r.x) - u.y, p);
    return r;
  endfunction

  // k*P as k repeated additions.
  function automatic pt_t refMul(input int k, input pt_t pp, input int p, input int ac);
    pt_t r = mkPt(1, 0, 0);
    for (int i = 0; i < k; i++) r = ptAdd(r, pp, p, ac);
    return r;
  endfunction

  // Number of engine requests the double-and-add walk needs, given its shortcuts.
  function automatic int refReqs(input int k, input pt_t pp, input int p, input int ac);
    pt_t acc;
    int n = 0;
    int msb = 0;
    if (k == 0) return 0;
    for (int i = 0; i < K_W; i++) if (((k >> i) & 1) == 1) msb = i;
    acc = pp;
    for (int i = msb - 1; i >= 0; i--) begin
      if (acc.inf || acc.y == 0) acc.inf = 1;
      else begin
        n++;
        acc = ptAdd(acc, acc, p, ac);
      end
      if (((k >> i) & 1) == 1) begin
        if (acc.inf) acc = pp;
        else if (acc.x == pp.x && acc.y != pp.y) acc.inf = 1;
        else begin
          n++;
          acc = ptAdd(acc, pp, p, ac);
        end
      end
    end
    return n;
  endfunction

  // Engine stub: answers each request after a random delay and watches the request port.
  initial begin
    pt_t ru, rv, rr;
    engIf.ec_out_valid = 1'b0;
    engIf.ec_Rx = '0;
    engIf.ec_Ry = '0;
    forever begin
      @(negedge clk);
      engIf.ec_out_valid = 1'b0;
      if (stubPending) begin
        if (stubDelay <= 1) begin
          engIf.ec_out_valid = 1'b1;
          engIf.ec_Rx = W'(stubRx);
          engIf.ec_Ry = W'(stubRy);
          stubPending = 0;
        end else begin
          stubDelay--;
        end
      end else if (strayReq) begin
        engIf.ec_out_valid = 1'b1;
        engIf.ec_Rx = W'(9);
        engIf.ec_Ry = W'(9);
        strayReq = 0;
      end
      if (engIf.ec_in_valid) begin
        reqCount++;
        reqCyc = cyc;
        checkOutput("singleOutstanding", int'(stubPending), 0);
        if (!stubSilent) begin
          ru = mkPt(0, int'(engIf.ec_Px), int'(engIf.ec_Py));
          rv = mkPt(0, int'(engIf.ec_Qx), int'(engIf.ec_Qy));
          rr = ptAdd(ru, rv, int'(engIf.ec_prime), int'(engIf.ec_a));
          stubRx = rr.inf ? 0 : rr.x;
          stubRy = rr.inf ? 0 : rr.y;
          stubDelay = $urandom_range(1, 4);
          stubPending = 1;
        end
      end else begin
        checkOutput("ecIdleOperands",
                    int'(engIf.ec_Px | engIf.ec_Py | engIf.ec_Qx | engIf.ec_Qy |
                         engIf.ec_prime | engIf.ec_a), 0);
      end
    end
  end

  // Issues one command and waits (bounded) for out_valid, poking in_valid while busy.
  task automatic applyStimulus(input int k, input int px, input int py, input int p,
                               input int a, output bit seen);
    seen = 0;
    reqCount = 0;
    cmdIf.in_k     = K_W'(k);
    cmdIf.in_Px    = W'(px);
    cmdIf.in_Py    = W'(py);
    cmdIf.in_prime = W'(p);
    cmdIf.in_a     = W'(a);
    cmdIf.in_valid = 1'b1;
    @(negedge clk);
    cmdIf.in_valid = 1'b0;
    checkOutput("busyAfterCapture", int'(cmdIf.busy), 1);
    for (int n = 0; n < MAXC && !seen; n++) begin
      @(negedge clk);
      cmdIf.in_valid = 1'b0;
      if (cmdIf.out_valid) begin
        seen = 1;
        doneCyc = cyc;
        checkOutput("busyAtDone", int'(cmdIf.busy), 0);
      end else if (cmdIf.busy && $urandom_range(0, 3) == 0) begin
        cmdIf.in_k     = K_W'($urandom);
        cmdIf.in_Px    = W'($urandom);
        cmdIf.in_Py    = W'($urandom);
        cmdIf.in_valid = 1'b1;
      end
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Checks the result strobe contents and that it lasts exactly one cycle.
  task automatic verifyResult(input string name, input pt_t exp, input int expReqs);
    checkOutput({name, ".inf"}, int'(cmdIf.out_inf), int'(exp.inf));
    checkOutput({name, ".Rx"}, int'(cmdIf.out_Rx), exp.inf ? 0 : exp.x);
    checkOutput({name, ".Ry"}, int'(cmdIf.out_Ry), exp.inf ? 0 : exp.y);
    checkOutput({name, ".err"}, int'(cmdIf.out_err), 0);
    checkOutput({name, ".reqs"}, reqCount, expReqs);
    @(negedge clk);
    checkOutput({name, ".validPulse"}, int'(cmdIf.out_valid), 0);
    checkOutput({name, ".RxCleared"}, int'(cmdIf.out_Rx), 0);
  endtask

  task automatic directedCase(input string name, input int k, input pt_t exp, input int expReqs);
    bit seen;
    applyStimulus(k, 2, 7, 11, 1, seen);
    checkOutput({name, ".seen"}, int'(seen), 1);
    if (seen) verifyResult(name, exp, expReqs);
    else pulseReset();
  endtask

  // Picks a random non-singular curve with small prime and a point on it.
  task automatic pickCurve(output int p, output int a, output int px, output int py);
    int primes[14];
    int b;
    pt_t pts[$];
    primes = '{11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61};
    p = 11; a = 1; b = 6;
    for (int tries = 0; tries < 50 && pts.size() == 0; tries++) begin
      p = primes[$urandom_range(0, 13)];
      a = $urandom_range(0, p - 1);
      b = $urandom_range(0, p - 1);
      if (modP(4 * a * a * a + 27 * b * b, p) != 0) begin
        for (int x = 0; x < p; x++)
          for (int y = 0; y < p; y++)
            if (modP(y * y - (x * x * x + a * x + b), p) == 0) pts.push_back(mkPt(0, x, y));
      end
    end
    if (pts.size() == 0) begin
      p = 11; a = 1; px = 2; py = 7;
    end else begin
      int idx = $urandom_range(0, pts.size() - 1);
      px = pts[idx].x;
      py = pts[idx].y;
    end
  endtask

  // Main sequence: reset, directed curve cases, random cases, timeout and reset abort.
  initial begin
    bit seen;
    int k, p, a, px, py;
    rst = 1'b1;
    cmdIf.in_valid = 1'b0;
    cmdIf.in_k = '0;
    cmdIf.in_Px = '0;
    cmdIf.in_Py = '0;
    cmdIf.in_prime = '0;
    cmdIf.in_a = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.busy", int'(cmdIf.busy), 0);
    checkOutput("reset.outValid", int'(cmdIf.out_valid), 0);
    checkOutput("reset.Rx", int'(cmdIf.out_Rx), 0);
    checkOutput("reset.Ry", int'(cmdIf.out_Ry), 0);
    checkOutput("reset.inf", int'(cmdIf.out_inf), 0);
    checkOutput("reset.err", int'(cmdIf.out_err), 0);
    checkOutput("reset.ecValid", int'(engIf.ec_in_valid), 0);

    directedCase("k0", 0, mkPt(1, 0, 0), 0);
    directedCase("k1", 1, mkPt(0, 2, 7), 0);
    directedCase("k2", 2, mkPt(0, 5, 2), 1);
    directedCase("k3", 3, mkPt(0, 8, 3), 2);
    directedCase("k13", 13, mkPt(1, 0, 0), 4);

    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 63);
      if (t % 3 == 0) begin
        p = 11; a = 1; px = 2; py = 7;
      end else begin
        pickCurve(p, a, px, py);
      end
      applyStimulus(k, px, py, p, a, seen);
      checkOutput("rand.seen", int'(seen), 1);
      if (seen) verifyResult("rand", refMul(k, mkPt(0, px, py), p, a),
                             refReqs(k, mkPt(0, px, py), p, a));
      else pulseReset();
    end

`ifdef EC_SM_TIMEOUT_EN
    stubSilent = 1;
    applyStimulus(2, 2, 7, 11, 1, seen);
    checkOutput("tmo.seen", int'(seen), 1);
    if (seen) begin
      checkOutput("tmo.err", int'(cmdIf.out_err), 1);
      checkOutput("tmo.inf", int'(cmdIf.out_inf), 0);
      checkOutput("tmo.Rx", int'(cmdIf.out_Rx), 0);
      checkOutput("tmo.Ry", int'(cmdIf.out_Ry), 0);
      checkOutput("tmo.latency", doneCyc - reqCyc, TIMEOUT + 1);
      @(negedge clk);
    end else begin
      pulseReset();
    end
    stubSilent = 0;
`endif

    stubSilent = 1;
    reqCount = 0;
    cmdIf.in_k = K_W'(2);
    cmdIf.in_Px = W'(2);
    cmdIf.in_Py = W'(7);
    cmdIf.in_prime = W'(11);
    cmdIf.in_a = W'(1);
    cmdIf.in_valid = 1'b1;
    @(negedge clk);
    cmdIf.in_valid = 1'b0;
    for (int n = 0; n < 20 && reqCount == 0; n++) @(negedge clk);
    checkOutput("rstTest.reqIssued", reqCount, 1);
    repeat (5) @(negedge clk);
    checkOutput("rstTest.busyBefore", int'(cmdIf.busy), 1);
    pulseReset();
    checkOutput("rstTest.busy", int'(cmdIf.busy), 0);
    checkOutput("rstTest.outValid", int'(cmdIf.out_valid), 0);
    checkOutput("rstTest.ecValid", int'(engIf.ec_in_valid), 0);
    checkOutput("rstTest.Rx", int'(cmdIf.out_Rx), 0);
    checkOutput("rstTest.inf", int'(cmdIf.out_inf), 0);
    strayReq = 1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checkOutput("rstTest.noValid", int'(cmdIf.out_valid), 0);
      checkOutput("rstTest.idleBusy", int'(cmdIf.busy), 0);
    end
    stubSilent = 0;
    directedCase("postReset", 3, mkPt(0, 8, 3), 2);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
